// File: rtl/varredura_display_pkg.sv
// Shared display constants, frame type and digit helpers for the
// multiplexed 4-digit hex display scanner.
package varredura_display_pkg;

  localparam int N_DIGITS = 4;
  localparam int DIGIT_W  = 4;
  localparam int VALUE_W  = N_DIGITS * DIGIT_W;

  // Active-low anodes: all ones means no digit enabled.
  localparam logic [N_DIGITS-1:0] AN_IDLE = 4'b1111;

  typedef logic [1:0] slot_t;

  // One displayable frame: four hex digits plus the per-digit blank mask.
  typedef struct packed {
    logic [VALUE_W-1:0]  value;
    logic [N_DIGITS-1:0] blank;
  } frame_t;

  // Select hex digit k of a packed value.
  function automatic logic [DIGIT_W-1:0] digit_of(input logic [VALUE_W-1:0] v,
                                                  input slot_t k);
    return v[{k, 2'b00} +: DIGIT_W];
  endfunction

  // Active-low anode pattern that enables only slot k.
  function automatic logic [N_DIGITS-1:0] anode_for(input slot_t k);
    return ~(4'b0001 << k);
  endfunction

  // Blank every digit above the most significant nonzero one; digit 0 is
  // always kept so that a zero value still shows "0".
  function automatic logic [N_DIGITS-1:0] lead_zero_mask(input logic [VALUE_W-1:0] v);
    logic [N_DIGITS-1:0] m;
    logic                all_zero;
    m        = 4'b0000;
    all_zero = 1'b1;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      all_zero = all_zero & (v[k*DIGIT_W +: DIGIT_W] == 4'h0);
      m[k]     = all_zero;
    end
    return m;
  endfunction

endpackage

// File: rtl/varredura_display_if.sv
// Display scanner bus: load strobe with value/blank in, scanned outputs out.
interface varredura_display_if;
  import varredura_display_pkg::*;

  logic                load;
  logic [VALUE_W-1:0]  value;
  logic [N_DIGITS-1:0] blank;
  logic [DIGIT_W-1:0]  hex_out;
  logic [N_DIGITS-1:0] an;
  logic                digit_blank;
  logic                frame_done;

  modport master (
    output load, value, blank,
    input  hex_out, an, digit_blank, frame_done
  );

  modport slave (
    input  load, value, blank,
    output hex_out, an, digit_blank, frame_done
  );
endinterface

// File: rtl/varredura_display_divisor.sv
// Reusable prescaler: counts 0..DIV-1 and asserts tick on the last count.
// DIV=1 keeps the counter at zero so tick is high every cycle.
module divisor_tick #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int                CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count_r;

  // Free-running modulo-DIV counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (count_r == LAST) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + CNT_W'(1);
    end
  end

  assign tick = (count_r == LAST);
endmodule

// File: rtl/varredura_display.sv
// Multiplexed 4-digit hex display scanner. A load is staged in a pending
// frame and promoted to the visible frame only at the end of a scan, so a
// frame never mixes old and new digits.
// Optional build macro: LEADING_ZERO_BLANK_EN (auto-blank leading zeros).
module varredura_display
  import varredura_display_pkg::*;
#(
  parameter int DIV = 50000
) (
  input logic               clk,
  input logic               rst_n,
  varredura_display_if.slave bus
);

  logic                tick_s;
  logic                wrap_s;
  slot_t               idx_r;
  slot_t               idx_next_s;
  frame_t              pend_r;
  frame_t              disp_r;
  frame_t              disp_next_s;
  logic [N_DIGITS-1:0] eff_blank_s;
  logic [DIGIT_W-1:0]  hex_next_s;
  logic [N_DIGITS-1:0] an_next_s;
  logic                db_next_s;
  logic [DIGIT_W-1:0]  hex_r;
  logic [N_DIGITS-1:0] an_r;
  logic                db_r;
  logic                fd_r;

  divisor_tick #(.DIV(DIV)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick_s)
  );

  // Next slot, next visible frame and the decoded outputs for that slot.
  always_comb begin
    wrap_s      = tick_s && (idx_r == 2'd3);
    idx_next_s  = idx_r;
    disp_next_s = disp_r;
    hex_next_s  = 4'h0;
    an_next_s   = AN_IDLE;
    db_next_s   = 1'b0;

    if (tick_s) begin
      idx_next_s = idx_r + 2'd1;
    end else begin
      idx_next_s = idx_r;
    end

    // A load landing on the wrap tick goes straight to the display.
    if (wrap_s && bus.load) begin
      disp_next_s = '{value: bus.value, blank: bus.blank};
    end else if (wrap_s) begin
      disp_next_s = pend_r;
    end else begin
      disp_next_s = disp_r;
    end

`ifdef LEADING_ZERO_BLANK_EN
    eff_blank_s = disp_next_s.blank | lead_zero_mask(disp_next_s.value);
`else
    eff_blank_s = disp_next_s.blank;
`endif

    if (eff_blank_s[idx_next_s]) begin
      an_next_s  = AN_IDLE;
      hex_next_s = 4'h0;
      db_next_s  = 1'b1;
    end else begin
      an_next_s  = anode_for(idx_next_s);
      hex_next_s = digit_of(disp_next_s.value, idx_next_s);
      db_next_s  = 1'b0;
    end
  end

  // Slot index, staged/visible frames and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r  <= 2'd0;
      pend_r <= '0;
      disp_r <= '0;
      hex_r  <= 4'h0;
      an_r   <= 4'b1110;
      db_r   <= 1'b0;
      fd_r   <= 1'b0;
    end else begin
      idx_r  <= idx_next_s;
      disp_r <= disp_next_s;
      if (bus.load) begin
        pend_r <= '{value: bus.value, blank: bus.blank};
      end
      hex_r  <= hex_next_s;
      an_r   <= an_next_s;
      db_r   <= db_next_s;
      fd_r   <= wrap_s;
    end
  end

  assign bus.hex_out     = hex_r;
  assign bus.an          = an_r;
  assign bus.digit_blank = db_r;
  assign bus.frame_done  = fd_r;

endmodule

// File: tb/tb_varredura_display.sv
// Directed bench for varredura_display with DIV=4 (16 cycles per frame).
module tb_varredura_display;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  int   n;
  int   fd_count;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [3:0] M_ZERO = 4'b1110;
  localparam logic [3:0] M_0070 = 4'b1100;
`else
  localparam logic [3:0] M_ZERO = 4'b0000;
  localparam logic [3:0] M_0070 = 4'b0000;
`endif

  varredura_display_if bus_if ();

  varredura_display #(.DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL %s (n=%0d): got %h expected %h", tag, n, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  // Expected outputs for the slot in progress at sample n.
  task automatic check_outputs(input logic [15:0] v, input logic [3:0] m);
    int         slot;
    logic [3:0] e_an;
    logic [3:0] e_hex;
    logic       e_db;
    slot = (n / 4) % 4;
    if (m[slot]) begin
      e_an  = 4'b1111;
      e_hex = 4'h0;
      e_db  = 1'b1;
    end else begin
      e_an  = ~(4'b0001 << slot);
      e_hex = v[slot*4 +: 4];
      e_db  = 1'b0;
    end
    check_val($sformatf("an_s%0d", slot), {12'h000, bus_if.an}, {12'h000, e_an});
    check_val($sformatf("hex_s%0d", slot), {12'h000, bus_if.hex_out}, {12'h000, e_hex});
    check_val($sformatf("dblank_s%0d", slot), {15'h0000, bus_if.digit_blank}, {15'h0000, e_db});
    check_val("frame_done", {15'h0000, bus_if.frame_done},
              {15'h0000, ((n % 16) == 0) && (n > 0)});
  endtask

  task automatic run_to(input int target, input logic [15:0] v, input logic [3:0] m);
    while (n < target) begin
      step();
      check_outputs(v, m);
    end
  endtask

  // One-cycle load strobe; the cycle it spans is still checked against cv/cm.
  task automatic load_pulse(input logic [15:0] lv, input logic [3:0] lb,
                            input logic [15:0] cv, input logic [3:0] cm);
    bus_if.load  = 1'b1;
    bus_if.value = lv;
    bus_if.blank = lb;
    step();
    bus_if.load  = 1'b0;
    check_outputs(cv, cm);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_hex"}, {12'h000, bus_if.hex_out}, 16'h0000);
    check_val({tag, "_an"}, {12'h000, bus_if.an}, 16'h000E);
    check_val({tag, "_dblank"}, {15'h0000, bus_if.digit_blank}, 16'h0000);
    check_val({tag, "_fdone"}, {15'h0000, bus_if.frame_done}, 16'h0000);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    n            = 0;
    fd_count     = 0;
    rst_n        = 1'b0;
    bus_if.load  = 1'b0;
    bus_if.value = 16'h0000;
    bus_if.blank = 4'b0000;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");

    rst_n = 1'b1;
    n     = 0;

    // 1234 loaded in frame 0, visible in frame 1, each digit held 4 cycles.
    load_pulse(16'h1234, 4'b0000, 16'h0000, M_ZERO);
    run_to(15, 16'h0000, M_ZERO);
    run_to(37, 16'h1234, 4'b0000);

    // ABCD loaded during slot 1: rest of frame stays 1234.
    load_pulse(16'hABCD, 4'b0000, 16'h1234, 4'b0000);
    run_to(47, 16'h1234, 4'b0000);
    run_to(63, 16'hABCD, 4'b0000);

    // Load on the wrap-tick cycle goes straight into slot 0.
    load_pulse(16'h5555, 4'b0000, 16'h5555, 4'b0000);
    run_to(70, 16'h5555, 4'b0000);

    // Mask blanks slot 2.
    load_pulse(16'h1234, 4'b0100, 16'h5555, 4'b0000);
    run_to(79, 16'h5555, 4'b0000);
    run_to(90, 16'h1234, 4'b0100);

    // Leading-zero values.
    load_pulse(16'h0070, 4'b0000, 16'h1234, 4'b0100);
    run_to(95, 16'h1234, 4'b0100);
    run_to(100, 16'h0070, M_0070);
    load_pulse(16'h0000, 4'b0000, 16'h0070, M_0070);
    run_to(111, 16'h0070, M_0070);
    run_to(130, 16'h0000, M_ZERO);

    // Leave a load pending, then reset mid-slot-2.
    load_pulse(16'hFFFF, 4'b0000, 16'h0000, M_ZERO);
    run_to(137, 16'h0000, M_ZERO);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n     = 0;

    // Pending FFFF must be gone; one frame_done per 16 cycles.
    for (int i = 0; i < 48; i++) begin
      step();
      check_outputs(16'h0000, M_ZERO);
      if (bus_if.frame_done) fd_count++;
    end
    check_val("fd_count", fd_count[15:0], 16'd3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/varredura_display.md
VARREDURA_DISPLAY -- requirements
Module: varredura_display

Interface
REQ-001 SHALL have parameter DIV, default 50000, clock cycles per digit slot (legal range 1..2^20).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 SHALL have port load  input  1  one-cycle strobe capturing value and blank.
REQ-005 SHALL have port value  input  16  four hex digits; digit k = value[4k+3:4k].
REQ-006 SHALL have port blank  input  4  per-digit blank mask; 1 = digit off.
REQ-007 SHALL have port hex_out  output  4  hex digit for the downstream 7-segment decoder.
REQ-008 SHALL have port an  output  4  digit enables, active-low, at most one bit low.
REQ-009 SHALL have port digit_blank  output  1  1 = current slot blanked.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse at the end of each 4-digit scan.

Function
REQ-011 SHALL run a prescaler counting 0..DIV-1 and wrapping; tick = (prescaler == DIV-1); DIV=1 SHALL tick every cycle.
REQ-012 SHALL hold a 2-bit slot index advancing 0->1->2->3->0 on each tick.
REQ-013 SHALL capture value/blank into a pending register on any cycle with load=1; a later load overwrites an earlier one.
REQ-014 SHALL copy pending into the display register on the tick where the index wraps 3->0.
REQ-015 SHALL, when load and the wrap tick coincide, put the newly loaded value/blank directly into display; no frame uses stale data.
REQ-016 SHALL register hex_out, an, and digit_blank, updating them on the same edge as the index, from the next index and the next display contents.
REQ-017 SHALL drive, for a visible slot k: an = ~(1<<k), hex_out = display digit k, digit_blank = 0.
REQ-018 SHALL drive, for a blanked slot: an = 4'b1111, hex_out = 0, digit_blank = 1.
REQ-019 SHALL pulse frame_done for exactly one cycle, registered, on the edge where the index wraps 3->0.
REQ-020 SHALL make load-to-display latency equal to the next wrap; a load during slot 3 SHALL appear at the following slot 0.

Reset
REQ-021 SHALL, while rst_n=0, force: prescaler=0, index=0, pending=0, display=0, mask=0, hex_out=0, an=4'b1110, digit_blank=0, frame_done=0.
REQ-022 SHALL, on reset deassertion, restart counting from prescaler 0, slot 0; the first tick occurs DIV cycles later.
REQ-023 SHALL discard a load pending at reset assertion mid-frame.

Configuration
REQ-024 SHALL recognise macro LEADING_ZERO_BLANK_EN.
REQ-025 SHALL, with LEADING_ZERO_BLANK_EN defined, auto-blank every digit above the most significant nonzero display digit; the result is OR'd with the mask; digit 0 is never auto-blanked (value 0 shows "0").
REQ-026 SHALL, without LEADING_ZERO_BLANK_EN, blank a digit only via the mask.

Structure
REQ-027 SHALL put N_DIGITS=4, the digit width of 4, and the active-low anode idle constant 4'b1111 in the shared display package.
REQ-028 SHALL implement the prescaler as sub-module divisor_tick (parameter DIV, outputs tick), reusable by other blocks.

Verification (DIV=4)
REQ-029 SHALL check: reset, then load value=16'h1234, mask=0 -> by the next frame, an/hex_out cycle 1110/4, 1101/3, 1011/2, 0111/1, each held 4 cycles.
REQ-030 SHALL check: load 16'hABCD during slot 1 of a frame showing 16'h1234 -> the rest of that frame shows 1234; the next frame shows D,C,B,A.
REQ-031 SHALL check: load on the exact wrap-tick cycle with 16'h5555 -> the immediately starting slot 0 shows 5.
REQ-032 SHALL check: mask=4'b0100 -> slot 2 gives an=1111, digit_blank=1, hex_out=0.
REQ-033 SHALL check: with LEADING_ZERO_BLANK_EN, value=16'h0070 -> slots 2,3 blanked, slots 0,1 show 0,7; value=0 -> only slot 0 lit, showing 0.
REQ-034 SHALL check: rst_n low for 1 cycle mid-slot-2 -> outputs take reset values immediately; frame_done pulses exactly once per 16 cycles afterwards.
